jtag_dmi_tap: RTL and testbench
===============================

Name: jtag_dmi_tap

Overview:
- JTAG Test Access Port with a RISC-V debug transport module (DTM) front-end.
- Converts TAP scans into debug-module-interface (DMI) request/response transactions.
- Sits between the chip JTAG pins and the debug module. Provides IDCODE, DTMCS, DMIACCESS and BYPASS registers behind a 5-bit IR.
- Debugger tooling uses it to halt harts, write DPC, and access memory via system-bus registers.

Parameters:
- IrLength, 5, instruction register width.
- IdCode, 32'h0000_0001, IDCODE value; bit 0 must be 1.
- DmiAbits, 7, DMI address width.

Ports:
- clk_i  in  1  TCK; all state changes on its rising edge.
- rst_ni  in  1  synchronous active-low reset (TRST equivalent).
- tms_i  in  1  test mode select.
- tdi_i  in  1  test data in.
- tdo_o  out  1  test data out.
- tdo_oe_o  out  1  high in Shift-IR/Shift-DR.
- dmi_req_valid_o  out  1  DMI request valid.
- dmi_req_ready_i  in  1  debug module accepts request.
- dmi_req_addr_o  out  DmiAbits  request address.
- dmi_req_op_o  out  2  1 = read, 2 = write.
- dmi_req_data_o  out  32  write data.
- dmi_resp_valid_i  in  1  response valid.
- dmi_resp_ready_o  out  1  always 1.
- dmi_resp_data_i  in  32  read data.
- dmi_resp_resp_i  in  2  0 = ok, nonzero = failure.

Behaviour:
- Reset (rst_ni = 0 at rising clk_i):
  - TAP state = Test-Logic-Reset; IR = IDCODE (5'h01).
  - dmi_req_valid_o = 0, tdo_oe_o = 0, tdo_o = 0.
  - Sticky error = 0, pending = 0, last address = 0, response data = 0.
- TAP FSM: standard IEEE 1149.1 16-state machine, advanced by tms_i each rising edge.
  - Five consecutive tms_i = 1 reach Test-Logic-Reset from any state.
  - Test-Logic-Reset also forces IR = IDCODE.
- IR path:
  - Capture-IR loads 5'b00001.
  - Shift-IR shifts LSB-first: tdi_i enters the MSB.
  - Update-IR latches the shifted value.
- Instruction decode: 0x01 IDCODE, 0x10 DTMCS, 0x11 DMIACCESS, 0x1F and all undefined codes select BYPASS.
- tdo_o = LSB of the selected shift register, registered at the same edge as the shift.
  - Therefore it is valid for the whole cycle the debugger samples.
- Data registers (Capture-DR contents):
  - IDCODE: 32 bits, captures IdCode.
  - BYPASS: 1 bit, captures 0.
  - DTMCS: 32 bits, captures {14'b0, dmihardreset 0, dmireset 0, 1'b0, idle 3'd1, dmistat[1:0], abits DmiAbits[5:0], version 4'd1}.
  - DTMCS Update-DR: bit16 = 1 clears the sticky error; bit17 = 1 clears the sticky error and drops any pending request (dmi_req_valid_o = 0).
  - DMIACCESS: DmiAbits+34 bits, layout {addr, data[31:0], op[1:0]}.
- DMIACCESS Capture-DR loads {last address, response data, status}:
  - status = 3 if a request is pending or the response is not yet received;
  - otherwise status = sticky error (0 ok, 2 failed, 3 busy).
- DMIACCESS Update-DR:
  - op = 0: no action.
  - op = 1 or 2, no pending request, sticky error = 0:
    - Drive addr/op/data onto dmi_req_* and assert dmi_req_valid_o.
    - Record the address; set pending.
  - op = 1 or 2 while pending: sticky error = 3; request dropped.
  - op = 1 or 2 while sticky error ≠ 0: request ignored.
  - op = 3: treated as no action.
- DMI handshake:
  - dmi_req_valid_o holds, with stable fields, until a cycle where dmi_req_ready_i = 1; it deasserts on the next edge.
  - Response is accepted on any cycle with dmi_resp_valid_i = 1.
  - On response: data register ← dmi_resp_data_i (reads only; writes keep the old data); pending cleared.
  - If dmi_resp_resp_i ≠ 0, sticky error = 2.
- Simultaneous events:
  - Response arriving on the same edge as a Capture-DR: the capture sees status 3, and the response is still latched.
  - Reset mid-transaction abandons the request immediately.
- dmistat in DTMCS mirrors the sticky error.

Test Plan:
- Reset, 5× tms_i = 1, go to Run-Test-Idle, shift 32-bit DR → shifted-out value = IdCode (0x00000001 default).
- IR = 0x1F, shift DR pattern 1011 → output is the pattern delayed by one bit, first bit 0.
- IR = 0x10, shift 32-bit DR → 0x00001071 (idle 1, abits 7, version 1, dmistat 0).
- IR = 0x11, shift {addr 0x10, data 0x00000001, op 2}, then Update → dmi_req_valid_o = 1, addr 0x10, op 2, data 1.
  - Hold dmi_req_ready_i = 0 for 3 cycles, then 1 → valid drops on the next edge.
- DMI read of addr 0x11; respond with data 0xDEADBEEF, resp 0; then scan op 0 → captured data 0xDEADBEEF, status 0.
- Issue a read, withhold the response, scan a second read → status 3.
  - Status stays 3 after the response arrives until DTMCS bit16 is written; afterwards status reads 0.

Source files
------------

// File: rtl/jtag_dmi_tap_if.sv
// DMI request/response channel between the JTAG debug transport and the debug module.
// Signal suffixes follow the TAP's point of view.
interface jtag_dmi_tap_if #(
    parameter int unsigned DmiAbits = 7
);
    logic                dmi_req_valid_o;
    logic                dmi_req_ready_i;
    logic [DmiAbits-1:0] dmi_req_addr_o;
    logic [1:0]          dmi_req_op_o;
    logic [31:0]         dmi_req_data_o;
    logic                dmi_resp_valid_i;
    logic                dmi_resp_ready_o;
    logic [31:0]         dmi_resp_data_i;
    logic [1:0]          dmi_resp_resp_i;

    modport master (
        output dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o, dmi_resp_ready_o,
        input  dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i
    );

    modport slave (
        input  dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o, dmi_resp_ready_o,
        output dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i
    );
endinterface

// File: rtl/jtag_dmi_tap.sv
// IEEE 1149.1 TAP with a RISC-V debug transport front-end (IDCODE, DTMCS, DMIACCESS, BYPASS).
// DMIACCESS scans become DMI requests; responses are latched for the next capture.
module jtag_dmi_tap #(
    parameter int unsigned IrLength = 5,
    parameter logic [31:0] IdCode   = 32'h0000_0001,
    parameter int unsigned DmiAbits = 7
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           tms_i,
    input  logic           tdi_i,
    output logic           tdo_o,
    output logic           tdo_oe_o,
    jtag_dmi_tap_if.master dmi
);
    localparam int unsigned DrW = DmiAbits + 34;
    localparam logic [IrLength-1:0] IrIdcode = IrLength'(5'h01);
    localparam logic [IrLength-1:0] IrDtmcs  = IrLength'(5'h10);
    localparam logic [IrLength-1:0] IrDmi    = IrLength'(5'h11);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI} dr_sel_e;

    tap_state_e          r_state, w_state_nxt;
    dr_sel_e             w_sel;
    logic [IrLength-1:0] r_ir, r_ir_sr;
    logic [DrW-1:0]      r_dr, w_dr_cap, w_dr_sh;
    logic                r_tdo;

    logic                r_req_valid;
    logic [DmiAbits-1:0] r_req_addr;
    logic [1:0]          r_req_op;
    logic [31:0]         r_req_data;
    logic                r_pending;
    logic [1:0]          r_err;
    logic [DmiAbits-1:0] r_last_addr;
    logic [31:0]         r_resp_data;
    logic                r_last_rd;

    logic [1:0]          w_status;
    logic [31:0]         w_dtmcs;
    logic [1:0]          w_up_op;
    logic [31:0]         w_up_data;
    logic [DmiAbits-1:0] w_up_addr;
    logic                w_upd_dr, w_dmi_req, w_dtm_upd;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= TLR;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TLR:      w_state_nxt = tms_i ? TLR    : RTI;
            RTI:      w_state_nxt = tms_i ? SEL_DR : RTI;
            SEL_DR:   w_state_nxt = tms_i ? SEL_IR : CAP_DR;
            CAP_DR:   w_state_nxt = tms_i ? EX1_DR : SH_DR;
            SH_DR:    w_state_nxt = tms_i ? EX1_DR : SH_DR;
            EX1_DR:   w_state_nxt = tms_i ? UPD_DR : PAUSE_DR;
            PAUSE_DR: w_state_nxt = tms_i ? EX2_DR : PAUSE_DR;
            EX2_DR:   w_state_nxt = tms_i ? UPD_DR : SH_DR;
            UPD_DR:   w_state_nxt = tms_i ? SEL_DR : RTI;
            SEL_IR:   w_state_nxt = tms_i ? TLR    : CAP_IR;
            CAP_IR:   w_state_nxt = tms_i ? EX1_IR : SH_IR;
            SH_IR:    w_state_nxt = tms_i ? EX1_IR : SH_IR;
            EX1_IR:   w_state_nxt = tms_i ? UPD_IR : PAUSE_IR;
            PAUSE_IR: w_state_nxt = tms_i ? EX2_IR : PAUSE_IR;
            EX2_IR:   w_state_nxt = tms_i ? UPD_IR : SH_IR;
            UPD_IR:   w_state_nxt = tms_i ? SEL_DR : RTI;
            default:  w_state_nxt = TLR;
        endcase
    end

    always_comb begin
        w_sel = DR_BYPASS;
        if (r_ir == IrIdcode)     w_sel = DR_IDCODE;
        else if (r_ir == IrDtmcs) w_sel = DR_DTMCS;
        else if (r_ir == IrDmi)   w_sel = DR_DMI;
    end

    // A pending request reports busy regardless of the sticky error.
    assign w_status = r_pending ? 2'd3 : r_err;
    assign w_dtmcs  = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, r_err, 6'(DmiAbits), 4'd1};

    // One shared shift register; tdi enters at the top of the selected register's length.
    always_comb begin
        w_dr_cap = '0;
        w_dr_sh  = DrW'(tdi_i);
        case (w_sel)
            DR_IDCODE: begin
                w_dr_cap = DrW'(IdCode);
                w_dr_sh  = DrW'({tdi_i, r_dr[31:1]});
            end
            DR_DTMCS: begin
                w_dr_cap = DrW'(w_dtmcs);
                w_dr_sh  = DrW'({tdi_i, r_dr[31:1]});
            end
            DR_DMI: begin
                w_dr_cap = {r_last_addr, r_resp_data, w_status};
                w_dr_sh  = {tdi_i, r_dr[DrW-1:1]};
            end
            default: ;
        endcase
    end

    assign w_up_op   = r_dr[1:0];
    assign w_up_data = r_dr[33:2];
    assign w_up_addr = r_dr[DrW-1:34];
    assign w_upd_dr  = (r_state == UPD_DR);
    assign w_dmi_req = w_upd_dr && (w_sel == DR_DMI) && (w_up_op == 2'd1 || w_up_op == 2'd2);
    assign w_dtm_upd = w_upd_dr && (w_sel == DR_DTMCS);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ir    <= IrIdcode;
            r_ir_sr <= '0;
            r_dr    <= '0;
            r_tdo   <= 1'b0;
        end else begin
            case (r_state)
                TLR:    r_ir <= IrIdcode;
                CAP_IR: r_ir_sr <= IrLength'(1);
                SH_IR: begin
                    r_ir_sr <= {tdi_i, r_ir_sr[IrLength-1:1]};
                    r_tdo   <= r_ir_sr[0];
                end
                UPD_IR: r_ir <= r_ir_sr;
                CAP_DR: r_dr <= w_dr_cap;
                SH_DR: begin
                    r_dr  <= w_dr_sh;
                    r_tdo <= r_dr[0];
                end
                default: ;
            endcase
        end
    end

    // Later assignments win: a scan update overrides a response landing on the same edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_op    <= 2'd0;
            r_req_data  <= '0;
            r_pending   <= 1'b0;
            r_err       <= 2'd0;
            r_last_addr <= '0;
            r_resp_data <= '0;
            r_last_rd   <= 1'b0;
        end else begin
            if (r_req_valid && dmi.dmi_req_ready_i) r_req_valid <= 1'b0;
            if (dmi.dmi_resp_valid_i) begin
                r_pending <= 1'b0;
                if (r_last_rd) r_resp_data <= dmi.dmi_resp_data_i;
                if (dmi.dmi_resp_resp_i != 2'd0) r_err <= 2'd2;
            end
            if (w_dtm_upd) begin
                if (r_dr[16] || r_dr[17]) r_err <= 2'd0;
                if (r_dr[17]) begin
                    r_pending   <= 1'b0;
                    r_req_valid <= 1'b0;
                end
            end
            if (w_dmi_req) begin
                if (r_pending) begin
                    r_err <= 2'd3;
                end else if (r_err == 2'd0) begin
                    r_req_valid <= 1'b1;
                    r_req_addr  <= w_up_addr;
                    r_req_op    <= w_up_op;
                    r_req_data  <= w_up_data;
                    r_pending   <= 1'b1;
                    r_last_addr <= w_up_addr;
                    r_last_rd   <= (w_up_op == 2'd1);
                end
            end
        end
    end

    assign tdo_o                = r_tdo;
    assign tdo_oe_o             = (r_state == SH_DR) || (r_state == SH_IR);
    assign dmi.dmi_req_valid_o  = r_req_valid;
    assign dmi.dmi_req_addr_o   = r_req_addr;
    assign dmi.dmi_req_op_o     = r_req_op;
    assign dmi.dmi_req_data_o   = r_req_data;
    assign dmi.dmi_resp_ready_o = 1'b1;
endmodule

// File: tb/tb_jtag_dmi_tap.sv
// Randomised scan/DMI traffic against a transaction-level model of the debug transport,
// with directed scenarios pinned to hand-computed values.
module tb_jtag_dmi_tap;
    localparam int AB    = 7;
    localparam int DMI_N = AB + 34;

    logic clk_i = 1'b0;
    logic rst_ni, tms_i, tdi_i;
    logic tdo_o, tdo_oe_o;

    jtag_dmi_tap_if #(.DmiAbits(AB)) dmi ();

    jtag_dmi_tap #(.IrLength(5), .IdCode(32'h0000_0001), .DmiAbits(AB)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .tms_i(tms_i), .tdi_i(tdi_i),
        .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o), .dmi(dmi)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0, n_total = 0;
    bit chk_en = 0, in_shift = 0, rand_ready = 0;

    // Transaction-level model of the DTM
    logic          m_valid, m_pending, m_last_rd;
    logic [1:0]    m_err, m_op;
    logic [AB-1:0] m_addr, m_last_addr;
    logic [31:0]   m_wdata, m_data;
    logic [4:0]    cur_ir;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_valid = 0; m_pending = 0; m_last_rd = 0; m_err = 0; m_op = 0;
        m_addr = 0; m_last_addr = 0; m_wdata = 0; m_data = 0; cur_ir = 5'h01;
    endtask

    task automatic model_resp(input logic [31:0] d, input logic [1:0] r);
        m_pending = 0;
        if (m_last_rd) m_data = d;
        if (r != 2'd0) m_err = 2'd2;
    endtask

    task automatic model_dmi_update(input logic [1:0] op, input logic [AB-1:0] a, input logic [31:0] d);
        if (op == 2'd1 || op == 2'd2) begin
            if (m_pending) m_err = 2'd3;
            else if (m_err == 2'd0) begin
                m_valid = 1; m_pending = 1; m_addr = a; m_op = op; m_wdata = d;
                m_last_addr = a; m_last_rd = (op == 2'd1);
            end
        end
    endtask

    function automatic logic [63:0] model_dtmcs();
        return 64'({14'b0, 3'b0, 3'd1, m_err, 6'd7, 4'd1});
    endfunction

    function automatic logic [1:0] rand_resp();
        return ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    endfunction

    // One TCK: inputs applied before the rising edge, tdo sampled on the falling edge.
    task automatic tck(input logic tms, input logic tdi, output logic tdo);
        bit drop;
        tms_i = tms; tdi_i = tdi;
        drop = m_valid && dmi.dmi_req_ready_i;
        @(posedge clk_i);
        @(negedge clk_i);
        tdo = tdo_o;
        if (drop) m_valid = 0;
        if (rand_ready) dmi.dmi_req_ready_i = ($urandom_range(0, 2) == 0);
    endtask

    task automatic idle(input int n);
        logic o;
        for (int i = 0; i < n; i++) tck(1'b0, 1'b0, o);
    endtask

    task automatic set_ir(input logic [4:0] ir);
        logic o;
        logic [4:0] cap;
        tck(1, 0, o); tck(1, 0, o); tck(0, 0, o); tck(0, 0, o);
        in_shift = 1;
        for (int i = 0; i < 5; i++) begin
            tck(i == 4, ir[i], o);
            cap[i] = o;
        end
        in_shift = 0;
        tck(1, 0, o); tck(0, 0, o);
        check("ir_capture", 64'(cap), 64'h1);
        cur_ir = ir;
    endtask

    task automatic scan_dr(input int n, input logic [63:0] din, input bit rac,
                           input logic [31:0] rdata, input logic [1:0] rresp, output logic [63:0] dout);
        logic o;
        dout = '0;
        tck(1, 0, o); tck(0, 0, o);
        if (rac) begin
            dmi.dmi_resp_valid_i = 1; dmi.dmi_resp_data_i = rdata; dmi.dmi_resp_resp_i = rresp;
        end
        tck(0, 0, o);
        if (rac) begin
            dmi.dmi_resp_valid_i = 0;
            model_resp(rdata, rresp);
        end
        in_shift = 1;
        for (int i = 0; i < n; i++) begin
            tck(i == n - 1, din[i], o);
            dout[i] = o;
        end
        in_shift = 0;
        tck(1, 0, o); tck(0, 0, o);
    endtask

    task automatic dmi_scan(input logic [1:0] op, input logic [AB-1:0] a, input logic [31:0] d,
                            input bit rac, input logic [31:0] rdata, input logic [1:0] rresp,
                            output logic [63:0] dout);
        logic [63:0] exp;
        if (cur_ir != 5'h11) set_ir(5'h11);
        exp = 64'({m_last_addr, m_data, (m_pending ? 2'd3 : m_err)});
        scan_dr(DMI_N, 64'({a, d, op}), rac, rdata, rresp, dout);
        check("dmi_capture", dout, exp);
        model_dmi_update(op, a, d);
    endtask

    task automatic dtmcs_scan(input bit b16, input bit b17, output logic [63:0] dout);
        logic [63:0] exp, din;
        if (cur_ir != 5'h10) set_ir(5'h10);
        exp = model_dtmcs();
        din = {32'h0, $urandom};
        din[16] = b16; din[17] = b17;
        scan_dr(32, din, 0, 0, 0, dout);
        check("dtmcs_capture", dout, exp);
        if (b16 || b17) m_err = 2'd0;
        if (b17) begin m_pending = 0; m_valid = 0; end
    endtask

    task automatic reg_scan(input logic [4:0] ir);
        logic [63:0] din, dout;
        if (cur_ir != ir) set_ir(ir);
        din = {$urandom, $urandom};
        if (ir == 5'h01) begin
            scan_dr(32, din, 0, 0, 0, dout);
            check("idcode_scan", dout, 64'h1);
        end else begin
            scan_dr(8, din, 0, 0, 0, dout);
            check("bypass_scan", dout, (din << 1) & 64'hFF);
        end
    endtask

    task automatic accept();
        logic o;
        dmi.dmi_req_ready_i = 1;
        tck(0, 0, o);
        dmi.dmi_req_ready_i = 0;
        check("req_drop", 64'(dmi.dmi_req_valid_o), 64'h0);
    endtask

    task automatic respond(input logic [31:0] d, input logic [1:0] r);
        logic o;
        dmi.dmi_resp_valid_i = 1; dmi.dmi_resp_data_i = d; dmi.dmi_resp_resp_i = r;
        tck(0, 0, o);
        dmi.dmi_resp_valid_i = 0;
        model_resp(d, r);
    endtask

    always @(negedge clk_i) begin
        #2;
        if (chk_en) begin
            check("tdo_oe", 64'(tdo_oe_o), 64'(in_shift));
            check("req_valid", 64'(dmi.dmi_req_valid_o), 64'(m_valid));
            check("resp_ready", 64'(dmi.dmi_resp_ready_o), 64'h1);
            if (m_valid) begin
                check("req_addr", 64'(dmi.dmi_req_addr_o), 64'(m_addr));
                check("req_op", 64'(dmi.dmi_req_op_o), 64'(m_op));
                check("req_data", 64'(dmi.dmi_req_data_o), 64'(m_wdata));
            end
        end
    end

    initial begin
        logic o;
        logic [63:0] dout;
        logic [1:0]  op;
        logic [4:0]  codes [5];
        int c;
        bit rac;
        codes = '{5'h01, 5'h1F, 5'h00, 5'h0A, 5'h12};
        rst_ni = 0; tms_i = 1; tdi_i = 0;
        dmi.dmi_req_ready_i = 0; dmi.dmi_resp_valid_i = 0;
        dmi.dmi_resp_data_i = 0; dmi.dmi_resp_resp_i = 0;
        model_reset();
        tck(1, 0, o); tck(1, 0, o);
        rst_ni = 1;
        chk_en = 1;
        check("reset_tdo", 64'(tdo_o), 64'h0);
        check("reset_oe", 64'(tdo_oe_o), 64'h0);
        for (int i = 0; i < 5; i++) tck(1, 0, o);
        tck(0, 0, o);

        // IDCODE selected out of reset
        scan_dr(32, 64'h0, 0, 0, 0, dout);
        check("idcode_reset", dout, 64'h1);

        // BYPASS: pattern 1,0,1,1 comes back one bit late behind a 0
        set_ir(5'h1F);
        scan_dr(4, 64'b1101, 0, 0, 0, dout);
        check("bypass_1011", dout, 64'hA);

        dtmcs_scan(0, 0, dout);
        check("dtmcs_value", dout, 64'h1071);

        // Write addr 0x10 data 1, held for 3 cycles then accepted
        dmi_scan(2'd2, 7'h10, 32'h1, 0, 0, 0, dout);
        check("wr_valid", 64'(dmi.dmi_req_valid_o), 64'h1);
        check("wr_addr", 64'(dmi.dmi_req_addr_o), 64'h10);
        check("wr_op", 64'(dmi.dmi_req_op_o), 64'h2);
        check("wr_data", 64'(dmi.dmi_req_data_o), 64'h1);
        idle(3);
        check("wr_hold", 64'(dmi.dmi_req_valid_o), 64'h1);
        accept();
        respond(32'h55, 2'd0);

        // Read addr 0x11 returning 0xDEADBEEF
        dmi_scan(2'd1, 7'h11, 32'h0, 0, 0, 0, dout);
        accept();
        respond(32'hDEADBEEF, 2'd0);
        dmi_scan(2'd0, 7'h0, 32'h0, 0, 0, 0, dout);
        check("rd_result", dout, 64'({7'h11, 32'hDEADBEEF, 2'd0}));

        // Overlapping read goes busy; sticky until cleared through DTMCS
        dmi_scan(2'd1, 7'h05, 32'h0, 0, 0, 0, dout);
        accept();
        dmi_scan(2'd1, 7'h06, 32'h0, 0, 0, 0, dout);
        check("busy_pending", 64'(dout[1:0]), 64'h3);
        respond(32'h12345678, 2'd0);
        dmi_scan(2'd0, 7'h0, 32'h0, 0, 0, 0, dout);
        check("busy_sticky", 64'(dout[1:0]), 64'h3);
        dtmcs_scan(1, 0, dout);
        check("dtmcs_busy", dout, 64'h1C71);
        dmi_scan(2'd0, 7'h0, 32'h0, 0, 0, 0, dout);
        check("busy_cleared", dout, 64'({7'h05, 32'h12345678, 2'd0}));

        // Response on the Capture-DR edge
        dmi_scan(2'd1, 7'h22, 32'h0, 0, 0, 0, dout);
        accept();
        dmi_scan(2'd0, 7'h0, 32'h0, 1, 32'hCAFEF00D, 2'd0, dout);
        check("cap_same_edge", 64'(dout[1:0]), 64'h3);
        dmi_scan(2'd0, 7'h0, 32'h0, 0, 0, 0, dout);
        check("cap_latched", dout, 64'({7'h22, 32'hCAFEF00D, 2'd0}));

        // Failed response: sticky 2 blocks new requests until dmihardreset
        dmi_scan(2'd2, 7'h30, 32'hAA, 0, 0, 0, dout);
        accept();
        respond(32'h0, 2'd2);
        dmi_scan(2'd1, 7'h31, 32'h0, 0, 0, 0, dout);
        check("err_status", 64'(dout[1:0]), 64'h2);
        check("err_ignored", 64'(dmi.dmi_req_valid_o), 64'h0);
        dtmcs_scan(0, 1, dout);
        check("dtmcs_err", dout, 64'h1871);

        // Reset in the middle of an unaccepted request
        dmi_scan(2'd2, 7'h40, 32'h77, 0, 0, 0, dout);
        rst_ni = 0;
        tck(0, 0, o);
        rst_ni = 1;
        model_reset();
        check("rst_drop", 64'(dmi.dmi_req_valid_o), 64'h0);
        tck(0, 0, o);
        scan_dr(32, 64'h0, 0, 0, 0, dout);
        check("rst_idcode", dout, 64'h1);
        dmi_scan(2'd0, 7'h0, 32'h0, 0, 0, 0, dout);
        check("rst_dmi", dout, 64'h0);

        // Randomised traffic
        rand_ready = 1;
        for (int it = 0; it < 300; it++) begin
            c = $urandom_range(0, 9);
            if (c <= 3) begin
                op = 2'($urandom_range(0, 3));
                if (c <= 1) op = ($urandom_range(0, 1) == 1) ? 2'd1 : 2'd2;
                rac = m_pending && !m_valid && ($urandom_range(0, 3) == 0);
                dmi_scan(op, 7'($urandom), $urandom, rac, $urandom, rand_resp(), dout);
            end else if (c <= 5) begin
                if (m_pending && !m_valid) respond($urandom, rand_resp());
                else idle($urandom_range(1, 4));
            end else if (c == 6) begin
                dtmcs_scan($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, dout);
            end else if (c == 7) begin
                reg_scan(codes[$urandom_range(0, 4)]);
            end else begin
                idle($urandom_range(1, 6));
            end
        end
        rand_ready = 0;
        dmi.dmi_req_ready_i = 0;
        idle(2);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
